// File: rtl/bus_dma_pkg.sv
// Shared constants and types for the bus DMA engine and its bus arbiter.
package bus_dma_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned STATE_W    = 2;

    localparam logic [STATE_W-1:0] IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] RUN    = 2'd1;
    localparam logic [STATE_W-1:0] FINISH = 2'd2;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/bus_dma_if.sv
// On-chip memory bus as seen by the DMA initiator (master) and the responders/arbiter (slave).
interface bus_dma_if;
    import bus_dma_pkg::*;

    logic  bus_req;
    logic  bus_gnt;
    addr_t read_addr;
    word_t read_data;
    addr_t write_addr;
    word_t write_data;
    logic  write_strobe;

    modport master (
        output bus_req, read_addr, write_addr, write_data, write_strobe,
        input  bus_gnt, read_data
    );

    modport slave (
        input  bus_req, read_addr, write_addr, write_data, write_strobe,
        output bus_gnt, read_data
    );
endinterface

// File: rtl/bus_dma_hold_buf.sv
// One-entry skid register catching a read word that returns in a cycle without bus grant.
module dma_hold_buf
    import bus_dma_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_load,
    input  logic  i_drain,
    input  word_t i_data,
    output logic  o_valid,
    output word_t o_data
);
    logic  r_valid;
    word_t r_data;

    // A load and a drain never coincide: loads only happen while the bus is not granted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/bus_dma.sv
// Bus initiator that block-copies or block-fills 16-bit words on the memory bus.
// Read data returns one cycle after read_addr; a hold buffer keeps words that return ungranted.
module bus_dma
    import bus_dma_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  addr_t                 src_addr,
    input  addr_t                 dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  word_t                 fill_value,
    output logic                  busy,
    output logic                  done,
    bus_dma_if.master             bus
);
    logic [STATE_W-1:0] r_state, w_state_nxt;
    logic  r_busy, r_done, r_mode, r_rd_pend;
    word_t r_fill;
    addr_t r_src, r_dst, r_rd_left, r_wr_left;

    logic  w_accept, w_rd_issue, w_wr_fire, w_hold_load, w_hold_drain, w_hold_valid;
    word_t w_hold_data, w_wr_data;

    assign w_accept = (r_state == IDLE) && start;

    // Next state plus per-cycle read/write decisions; a held word is written before newer data.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_issue  = 1'b0;
        w_wr_fire   = 1'b0;
        w_hold_load = 1'b0;
        w_wr_data   = r_fill;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = (length == '0) ? FINISH : RUN;
            end
            RUN: begin
                if (r_mode == MODE_FILL) begin
                    w_wr_fire = bus.bus_gnt;
                end else begin
                    w_wr_fire   = bus.bus_gnt & (w_hold_valid | r_rd_pend);
                    w_rd_issue  = bus.bus_gnt & (r_rd_left != '0);
                    w_hold_load = ~bus.bus_gnt & r_rd_pend;
                    w_wr_data   = w_hold_valid ? w_hold_data : bus.read_data;
                end
                if (w_wr_fire && (r_wr_left == ADDR_WIDTH'(1))) w_state_nxt = FINISH;
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_hold_drain = w_wr_fire & w_hold_valid;

    dma_hold_buf u_hold_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_hold_load),
        .i_drain (w_hold_drain),
        .i_data  (bus.read_data),
        .o_valid (w_hold_valid),
        .o_data  (w_hold_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == FINISH);
        end
    end

    // Transfer parameters are captured once at accept; pointers wrap naturally at 16 bits.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mode    <= MODE_COPY;
            r_fill    <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_rd_left <= '0;
            r_wr_left <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_issue;
            if (w_accept) begin
                r_mode    <= mode;
                r_fill    <= fill_value;
                r_src     <= src_addr;
                r_dst     <= dst_addr;
                r_wr_left <= length;
                r_rd_left <= (mode == MODE_COPY) ? length : '0;
            end else begin
                if (w_rd_issue) begin
                    r_src     <= r_src + ADDR_WIDTH'(1);
                    r_rd_left <= r_rd_left - ADDR_WIDTH'(1);
                end
                if (w_wr_fire) begin
                    r_dst     <= r_dst + ADDR_WIDTH'(1);
                    r_wr_left <= r_wr_left - ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign bus.bus_req      = r_busy;
    assign bus.read_addr    = r_src;
    assign bus.write_addr   = r_dst;
    // Strobe must follow the grant within the same cycle, so it is decoded, not registered.
    assign bus.write_strobe = w_wr_fire & i_rst_n;
    assign bus.write_data   = w_wr_fire ? w_wr_data : '0;
endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: vector table of transfers plus reset corner sequences.
module tb_bus_dma;
    import bus_dma_pkg::*;

    typedef struct {
        logic        mode;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [15:0] fill;
        logic [15:0] gnt_off;     // bit c set: grant low in cycle c after accept
        int          exp_writes;
        int          exp_done;    // cycle after accept in which done pulses
        logic [15:0] exp_a0;
        logic [15:0] exp_d0;
        logic [15:0] exp_al;
        logic [15:0] exp_dl;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } memchk_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode;
    logic [15:0] src_addr, dst_addr, length, fill_value;
    logic        busy, done;
    logic [15:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    bus_dma_if bus_if ();

    bus_dma dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    // Responder: 256 words, registered read, write-first on a same-address collision.
    always @(posedge clk) begin
        if (bus_if.write_strobe && bus_if.write_addr < 16'h0100)
            mem[bus_if.write_addr[7:0]] <= bus_if.write_data;
        if (bus_if.read_addr < 16'h0100)
            bus_if.read_data <= (bus_if.write_strobe && bus_if.write_addr == bus_if.read_addr)
                              ? bus_if.write_data : mem[bus_if.read_addr[7:0]];
        else
            bus_if.read_data <= 16'hDEAD;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          nw = 0;
        int          done_at = -1;
        int          bad_gnt = 0;
        int          noisy = 0;
        logic        busy_at_done = 1'b0;
        logic        req_at_done = 1'b0;
        logic [15:0] a0 = '0, d0 = '0, al = '0, dl = '0;
        @(negedge clk);
        start = 1'b1; mode = v.mode; src_addr = v.src; dst_addr = v.dst;
        length = v.len; fill_value = v.fill; bus_if.bus_gnt = 1'b1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 2 && v.exp_done >= 3) begin
                // a start during a transfer with scrambled inputs must be ignored
                start = 1'b1; mode = ~v.mode; src_addr = 16'h0066; dst_addr = 16'h0066;
                length = 16'h0005; fill_value = 16'hFFFF;
            end
            bus_if.bus_gnt = (c < 16) ? ~v.gnt_off[c] : 1'b1;
            #1;
            if (bus_if.write_strobe) begin
                if (!bus_if.bus_gnt) bad_gnt++;
                if (nw == 0) begin a0 = bus_if.write_addr; d0 = bus_if.write_data; end
                al = bus_if.write_addr; dl = bus_if.write_data;
                nw++;
            end
            if (done) begin
                done_at = c; busy_at_done = busy; req_at_done = bus_if.bus_req;
            end
        end
        chk($sformatf("v%0d_done_cycle", id), done_at, v.exp_done);
        chk($sformatf("v%0d_num_writes", id), nw, v.exp_writes);
        chk($sformatf("v%0d_strobe_without_gnt", id), bad_gnt, 0);
        chk($sformatf("v%0d_busy_at_done", id), busy_at_done, 1);
        chk($sformatf("v%0d_req_at_done", id), req_at_done, 1);
        if (v.exp_writes > 0) begin
            chk($sformatf("v%0d_first_addr", id), a0, v.exp_a0);
            chk($sformatf("v%0d_first_data", id), d0, v.exp_d0);
            chk($sformatf("v%0d_last_addr", id), al, v.exp_al);
            chk($sformatf("v%0d_last_data", id), dl, v.exp_dl);
        end
        @(negedge clk);
        bus_if.bus_gnt = 1'b1;
        #1;
        chk($sformatf("v%0d_done_pulse_len", id), done, 0);
        chk($sformatf("v%0d_busy_after_done", id), busy, 0);
        repeat (6) begin
            @(negedge clk); #1;
            if (bus_if.write_strobe || busy || done) noisy++;
        end
        chk($sformatf("v%0d_idle_quiet", id), noisy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t    vecs [8];
        vec_t    vtmp;
        memchk_t mchk [28];
        int      noisy;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        mem[8'h10] = 16'hAAAA; mem[8'h11] = 16'hBBBB;
        mem[8'h12] = 16'hCCCC; mem[8'h13] = 16'hDDDD;

        //            mode       src      dst      len  fill     gnt_off  nw done a0       d0       al       dl
        vecs[0] = '{MODE_COPY, 16'h0010, 16'h0080, 16'd4, 16'h0000, 16'h0000, 4, 6, 16'h0080, 16'hAAAA, 16'h0083, 16'hDDDD};
        vecs[1] = '{MODE_FILL, 16'h0000, 16'h00FE, 16'd3, 16'h5A5A, 16'h0000, 3, 4, 16'h00FE, 16'h5A5A, 16'h0100, 16'h5A5A};
        vecs[2] = '{MODE_COPY, 16'h0020, 16'h0040, 16'd0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{MODE_COPY, 16'h0010, 16'h0090, 16'd4, 16'h0000, 16'h0004, 4, 7, 16'h0090, 16'hAAAA, 16'h0093, 16'hDDDD};
        vecs[4] = '{MODE_FILL, 16'h0000, 16'hFFFF, 16'd2, 16'h1234, 16'h0000, 2, 3, 16'hFFFF, 16'h1234, 16'h0000, 16'h1234};
        vecs[5] = '{MODE_COPY, 16'h0030, 16'h0031, 16'd3, 16'h0000, 16'h0000, 3, 5, 16'h0031, 16'h0130, 16'h0033, 16'h0130};
        vecs[6] = '{MODE_FILL, 16'h0000, 16'h0050, 16'd1, 16'hBEEF, 16'h0006, 1, 4, 16'h0050, 16'hBEEF, 16'h0050, 16'hBEEF};
        vecs[7] = '{MODE_COPY, 16'h0010, 16'h00A0, 16'd2, 16'h0000, 16'h0008, 2, 5, 16'h00A0, 16'hAAAA, 16'h00A1, 16'hBBBB};

        mchk = '{'{8'h80, 16'hAAAA}, '{8'h83, 16'hDDDD}, '{8'h84, 16'h0184}, '{8'hFE, 16'h5A5A},
                 '{8'hFF, 16'h5A5A}, '{8'h00, 16'h1234}, '{8'h01, 16'h0101}, '{8'h40, 16'h0140},
                 '{8'h90, 16'hAAAA}, '{8'h91, 16'hBBBB}, '{8'h92, 16'hCCCC}, '{8'h93, 16'hDDDD},
                 '{8'h94, 16'h0194}, '{8'h31, 16'h0130}, '{8'h33, 16'h0130}, '{8'h34, 16'h0134},
                 '{8'h50, 16'hBEEF}, '{8'h51, 16'h0151}, '{8'hA0, 16'hAAAA}, '{8'hA1, 16'hBBBB},
                 '{8'hA2, 16'h01A2}, '{8'hC0, 16'hAAAA}, '{8'hC1, 16'hBBBB}, '{8'hC3, 16'h01C3},
                 '{8'hD0, 16'hCCCC}, '{8'hD1, 16'hDDDD}, '{8'hD2, 16'h01D2}, '{8'h66, 16'h0166}};

        rst_n = 1'b0; start = 1'b0; mode = MODE_COPY; src_addr = '0; dst_addr = '0;
        length = '0; fill_value = '0; bus_if.bus_gnt = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bus_req", bus_if.bus_req, 0);
        chk("rst_write_strobe", bus_if.write_strobe, 0);
        chk("rst_read_addr", bus_if.read_addr, 0);
        chk("rst_write_addr", bus_if.write_addr, 0);
        chk("rst_write_data", bus_if.write_data, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of a long copy, then a fresh transfer
        @(negedge clk);
        start = 1'b1; mode = MODE_COPY; src_addr = 16'h0010; dst_addr = 16'h00C0;
        length = 16'd8; bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_busy_before", busy, 1);
        chk("midrst_strobe_before", bus_if.write_strobe, 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_strobe", bus_if.write_strobe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_bus_req", bus_if.bus_req, 0);
        rst_n = 1'b1;
        noisy = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (done || bus_if.write_strobe || busy) noisy++;
        end
        chk("midrst_no_done_after", noisy, 0);
        vtmp = '{MODE_COPY, 16'h0012, 16'h00D0, 16'd2, 16'h0000, 16'h0000, 2, 4, 16'h00D0, 16'hCCCC, 16'h00D1, 16'hDDDD};
        run_vec(vtmp, 8);

        for (int i = 0; i < 28; i++)
            chk($sformatf("mem_%02h", mchk[i].addr), mem[mchk[i].addr], mchk[i].data);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
